// File: rtl/mem_store_pkg.sv
// Shared definitions for the data-memory store path: size codes, FSM states
// and the alignment rule used to reject requests before touching memory.
package mem_store_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_MERGE = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    // The illegal size code is folded in here so a single test rejects a request.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_merge.sv
// Big-endian lane insert: overwrites the byte/halfword selected by lane in
// old_word with the low bits of data; every other bit is passed through.
module store_merge
    import mem_store_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] data,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    output logic [31:0] new_word
);

    always_comb begin
        new_word = old_word;
        case (size)
            SZ_BYTE: begin
                case (lane)
                    2'd0:    new_word[31:24] = data[7:0];
                    2'd1:    new_word[23:16] = data[7:0];
                    2'd2:    new_word[15:8]  = data[7:0];
                    default: new_word[7:0]   = data[7:0];
                endcase
            end
            SZ_HALF: begin
                if (lane[1]) begin
                    new_word[15:0] = data[15:0];
                end else begin
                    new_word[31:16] = data[15:0];
                end
            end
            SZ_WORD: new_word = data;
            default: new_word = old_word;
        endcase
    end

endmodule

// File: rtl/mem_store_unit.sv
// Store path of the memory stage: narrows register data to sb/sh/sw and
// writes it into a word-only memory, using read-modify-write for sub-words.
module mem_store_unit
#(
    parameter int ADDR_W = 32
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    input  logic [1:0]        st_size,
    output logic              st_done,
    output logic              st_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_req,
    input  logic              mem_rd_ack,
    input  logic [31:0]       mem_rdata,
    output logic              mem_wr_req,
    input  logic              mem_wr_ack,
    output logic [31:0]       mem_wdata
);

    import mem_store_pkg::*;

    // Handshakes: st_valid/st_ready transfer on a rising edge when both are
    // high; mem_*_req is held from the first cycle of a phase until the
    // matching ack (an ack in that first cycle counts) and acks seen while
    // the matching request is low have no effect.

    state_t      state;
    state_t      next_state;

    logic [1:0]  addr_lo_q;
    logic [31:0] data_q;
    logic [1:0]  size_q;
    logic [31:0] rd_word_q;
    logic [31:0] merged_word;
    logic        accept;

    assign accept = st_valid && st_ready;

    store_merge u_merge (
        .old_word (rd_word_q),
        .data     (data_q),
        .size     (size_q),
        .lane     (addr_lo_q),
        .new_word (merged_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_misaligned(st_size, st_addr[1:0])) begin
                        next_state = ST_ERR;
                    end else if (st_size == SZ_WORD) begin
                        next_state = ST_WRITE;
                    end else begin
                        next_state = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (mem_rd_ack) begin
                    next_state = ST_MERGE;
                end
            end
            ST_MERGE: next_state = ST_WRITE;
            ST_WRITE: begin
                if (mem_wr_ack) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: next_state = ST_IDLE;
            ST_ERR:  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Request capture and memory-side data; mem_addr/mem_wdata only move in
    // IDLE and MERGE, so they hold steady across every request phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_lo_q <= 2'b00;
            data_q    <= 32'h0;
            size_q    <= SZ_BYTE;
            rd_word_q <= 32'h0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        addr_lo_q <= st_addr[1:0];
                        data_q    <= st_data;
                        size_q    <= st_size;
                        mem_addr  <= {st_addr[ADDR_W-1:2], 2'b00};
                        if (st_size == SZ_WORD) begin
                            mem_wdata <= st_data;
                        end
                    end
                end
                ST_READ: begin
                    if (mem_rd_ack) begin
                        rd_word_q <= mem_rdata;
                    end
                end
                ST_MERGE: mem_wdata <= merged_word;
                default: begin
                end
            endcase
        end
    end

    assign st_ready   = (state == ST_IDLE);
    assign st_done    = (state == ST_DONE);
    assign st_err     = (state == ST_ERR);
    assign mem_rd_req = (state == ST_READ);
    assign mem_wr_req = (state == ST_WRITE);

    a_done_err_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(st_done && st_err));

    a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
        ((mem_rd_req && $past(mem_rd_req)) || (mem_wr_req && $past(mem_wr_req)))
        |-> $stable(mem_addr));

endmodule

// File: tb/tb_mem_store_unit.sv
// Directed bench for mem_store_unit with a small word memory model whose
// read/write ack latencies can be stretched.
module tb_mem_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_size;
    logic        st_done;
    logic        st_err;
    logic [31:0] mem_addr;
    logic        mem_rd_req;
    logic        mem_rd_ack;
    logic [31:0] mem_rdata;
    logic        mem_wr_req;
    logic        mem_wr_ack;
    logic [31:0] mem_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    mem_store_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .st_valid   (st_valid),
        .st_ready   (st_ready),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_size    (st_size),
        .st_done    (st_done),
        .st_err     (st_err),
        .mem_addr   (mem_addr),
        .mem_rd_req (mem_rd_req),
        .mem_rd_ack (mem_rd_ack),
        .mem_rdata  (mem_rdata),
        .mem_wr_req (mem_wr_req),
        .mem_wr_ack (mem_wr_ack),
        .mem_wdata  (mem_wdata)
    );

    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [31:0] mem_words [0:63];
    int          rd_delay = 0;
    int          wr_delay = 0;
    logic        stray_en = 1'b0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          wr_count = 0;
    logic [31:0] last_wr_addr = 32'h0;
    logic [31:0] last_wr_data = 32'h0;
    logic        pre_en = 1'b0;
    logic [31:0] pre_addr = 32'h0;
    logic [31:0] pre_val = 32'h0;

    assign mem_rdata  = mem_words[mem_addr[7:2]];
    // stray_en raises the opposite ack during each phase; it must be ignored
    assign mem_rd_ack = (mem_rd_req && (rd_cnt == rd_delay)) || (stray_en && mem_wr_req);
    assign mem_wr_ack = (mem_wr_req && (wr_cnt == wr_delay)) || (stray_en && mem_rd_req);

    always @(posedge clk) begin
        rd_cnt <= (mem_rd_req && !mem_rd_ack) ? rd_cnt + 1 : 0;
        wr_cnt <= (mem_wr_req && !mem_wr_ack) ? wr_cnt + 1 : 0;
        if (pre_en) begin
            mem_words[pre_addr[7:2]] <= pre_val;
        end
        if (mem_wr_req && mem_wr_ack) begin
            mem_words[mem_addr[7:2]] <= mem_wdata;
            wr_count     <= wr_count + 1;
            last_wr_addr <= mem_addr;
            last_wr_data <= mem_wdata;
        end
    end

    // ---------------- driver tasks ----------------
    int   r_done, r_err, r_rd, r_wr_first, r_addr_bad, r_wdata_bad, r_both;
    logic r_ready;

    task automatic preset(input logic [31:0] addr, input logic [31:0] val);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = addr; pre_val = val;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // Issues one request and records per-cycle observations; cycle 1 is the
    // cycle right after the accepting edge.
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
        logic [31:0] prev_wdata;
        logic        prev_wr;
        @(negedge clk);
        st_valid = 1'b1; st_addr = addr; st_data = data; st_size = size;
        @(posedge clk); #1;
        st_valid = 1'b0; st_addr = 32'hFFFF_FFFF; st_data = 32'h5A5A_5A5A; st_size = 2'b11;
        r_done = -1; r_err = -1; r_rd = 0; r_wr_first = -1;
        r_addr_bad = 0; r_wdata_bad = 0; r_both = 0;
        prev_wr = 1'b0; prev_wdata = 32'h0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            if (mem_rd_req) r_rd++;
            if (mem_wr_req && r_wr_first < 0) r_wr_first = k;
            if ((mem_rd_req || mem_wr_req) && mem_addr !== {addr[31:2], 2'b00}) r_addr_bad++;
            if (mem_wr_req && prev_wr && mem_wdata !== prev_wdata) r_wdata_bad++;
            if (st_done && st_err) r_both++;
            prev_wr = mem_wr_req;
            prev_wdata = mem_wdata;
            if (st_done) r_done = k;
            if (st_err) r_err = k;
            if (st_done || st_err) break;
        end
        @(posedge clk); #1;
        r_ready = st_ready;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_tests++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", st_ready); end
        n_tests++; if ({st_done, st_err, mem_rd_req, mem_wr_req} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {st_done, st_err, mem_rd_req, mem_wr_req}); end
        n_tests++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        n_tests++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    endtask

    task automatic test_sw();
        int wc0;
        wc0 = wr_count;
        run_txn(32'h100, 32'hDEADBEEF, 2'b10);
        n_tests++; if (r_rd !== 0) begin n_fail++; $display("FAIL sw_no_read: got %0d read cycles want 0", r_rd); end
        n_tests++; if (r_wr_first !== 1) begin n_fail++; $display("FAIL sw_write_at: got %0d want 1", r_wr_first); end
        n_tests++; if (r_done !== 2) begin n_fail++; $display("FAIL sw_done_at: got %0d want 2", r_done); end
        n_tests++; if (r_ready !== 1'b1) begin n_fail++; $display("FAIL sw_ready_after: got %b want 1", r_ready); end
        n_tests++; if (last_wr_addr !== 32'h100 || last_wr_data !== 32'hDEADBEEF || wr_count !== wc0 + 1) begin
            n_fail++; $display("FAIL sw_write: got %h@%h n=%0d want deadbeef@00000100 n=%0d",
                               last_wr_data, last_wr_addr, wr_count - wc0, 1); end
        n_tests++; if (r_addr_bad !== 0) begin n_fail++; $display("FAIL sw_addr: got %0d bad cycles want 0", r_addr_bad); end
    endtask

    task automatic test_sub_word();
        logic [31:0] t_addr [5] = '{32'h102, 32'h100, 32'h103, 32'h106, 32'h104};
        logic [31:0] t_data [5] = '{32'h000000AB, 32'h00000055, 32'h123456CD, 32'hFFFFCAFE, 32'hFFFFCAFE};
        logic [1:0]  t_size [5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
        logic [31:0] t_exp  [5] = '{32'h1122AB44, 32'h55223344, 32'h112233CD, 32'h1122CAFE, 32'hCAFE3344};
        for (int i = 0; i < 5; i++) begin
            preset({t_addr[i][31:2], 2'b00}, 32'h11223344);
            run_txn(t_addr[i], t_data[i], t_size[i]);
            n_tests++; if (r_done !== 4 || r_wr_first !== 3 || r_rd !== 1) begin
                n_fail++; $display("FAIL sub_timing[%0d]: got done=%0d wr=%0d rd=%0d want 4 3 1",
                                   i, r_done, r_wr_first, r_rd); end
            n_tests++; if (last_wr_data !== t_exp[i] || last_wr_addr !== {t_addr[i][31:2], 2'b00}) begin
                n_fail++; $display("FAIL sub_data[%0d]: got %h@%h want %h@%h", i, last_wr_data,
                                   last_wr_addr, t_exp[i], {t_addr[i][31:2], 2'b00}); end
            n_tests++; if (r_addr_bad !== 0 || r_ready !== 1'b1) begin
                n_fail++; $display("FAIL sub_addr_ready[%0d]: got bad=%0d ready=%b want 0 1", i, r_addr_bad, r_ready); end
        end
    endtask

    task automatic test_err();
        logic [31:0] e_addr [3] = '{32'h101, 32'h102, 32'h100};
        logic [1:0]  e_size [3] = '{2'b01, 2'b10, 2'b11};
        int wc0;
        for (int i = 0; i < 3; i++) begin
            wc0 = wr_count;
            run_txn(e_addr[i], 32'h01020304, e_size[i]);
            n_tests++; if (r_err !== 1 || r_done !== -1) begin
                n_fail++; $display("FAIL err_pulse[%0d]: got err=%0d done=%0d want 1 -1", i, r_err, r_done); end
            n_tests++; if (r_rd !== 0 || r_wr_first !== -1 || wr_count !== wc0) begin
                n_fail++; $display("FAIL err_no_mem[%0d]: got rd=%0d wr=%0d writes=%0d want 0 -1 0",
                                   i, r_rd, r_wr_first, wr_count - wc0); end
            n_tests++; if (r_ready !== 1'b1) begin n_fail++; $display("FAIL err_ready[%0d]: got %b want 1", i, r_ready); end
        end
    endtask

    task automatic test_wait_states();
        preset(32'h108, 32'h11223344);
        rd_delay = 3; wr_delay = 2; stray_en = 1'b1;
        run_txn(32'h10A, 32'h000000AB, 2'b00);
        rd_delay = 0; wr_delay = 0; stray_en = 1'b0;
        n_tests++; if (r_done !== 9) begin n_fail++; $display("FAIL wait_done_at: got %0d want 9", r_done); end
        n_tests++; if (r_rd !== 4 || r_wr_first !== 6) begin
            n_fail++; $display("FAIL wait_phases: got rd=%0d wr_first=%0d want 4 6", r_rd, r_wr_first); end
        n_tests++; if (r_addr_bad !== 0 || r_wdata_bad !== 0) begin
            n_fail++; $display("FAIL wait_stable: got addr_bad=%0d wdata_bad=%0d want 0 0", r_addr_bad, r_wdata_bad); end
        n_tests++; if (last_wr_data !== 32'h1122AB44 || last_wr_addr !== 32'h108) begin
            n_fail++; $display("FAIL wait_data: got %h@%h want 1122ab44@00000108", last_wr_data, last_wr_addr); end
        n_tests++; if (r_both !== 0) begin n_fail++; $display("FAIL wait_done_err_both: got %0d want 0", r_both); end
    endtask

    task automatic test_reset_mid();
        int wc0;
        int done_seen;
        wc0 = wr_count;
        done_seen = 0;
        wr_delay = 4;
        @(negedge clk);
        st_valid = 1'b1; st_addr = 32'h10C; st_data = 32'hCAFEF00D; st_size = 2'b10;
        @(posedge clk); #1;
        st_valid = 1'b0;
        @(posedge clk); #3;
        n_tests++; if (mem_wr_req !== 1'b1) begin n_fail++; $display("FAIL mid_in_write: got %b want 1", mem_wr_req); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (mem_wr_req !== 1'b0 || st_ready !== 1'b1 || st_done !== 1'b0) begin
            n_fail++; $display("FAIL mid_async: got wr_req=%b ready=%b done=%b want 0 1 0", mem_wr_req, st_ready, st_done); end
        n_tests++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            n_fail++; $display("FAIL mid_regs: got addr=%h wdata=%h want 0 0", mem_addr, mem_wdata); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (st_done) done_seen++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        wr_delay = 0;
        @(posedge clk); #1;
        if (st_done) done_seen++;
        n_tests++; if (done_seen !== 0 || wr_count !== wc0) begin
            n_fail++; $display("FAIL mid_abandon: got done=%0d writes=%0d want 0 0", done_seen, wr_count - wc0); end
        run_txn(32'h10C, 32'h0BADF00D, 2'b10);
        n_tests++; if (r_done !== 2 || last_wr_data !== 32'h0BADF00D || last_wr_addr !== 32'h10C) begin
            n_fail++; $display("FAIL mid_recover: got done=%0d %h@%h want 2 0badf00d@0000010c",
                               r_done, last_wr_data, last_wr_addr); end
    endtask

    initial begin
        rst_n = 1'b0;
        st_valid = 1'b0; st_addr = 32'h0; st_data = 32'h0; st_size = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_sw();
        test_sub_word();
        test_err();
        test_wait_states();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_store_unit.md
Name: mem_store_unit

Overview:
- Store path of the data-memory stage. It performs the inverse of the immediate/load extender: it narrows register data to the store size (sb/sh/sw) and writes it into a word-only data memory.
- Sub-word stores are done as read-modify-write, because the memory has no byte enables.
- It sits between the EX/MEM store request and the single-port data memory, with valid/ready on the CPU side and req/ack on the memory side.

Parameters:
- ADDR_W, 32, byte-address width on both sides.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- st_valid  in  1  store request valid
- st_ready  out  1  unit can accept a request (high only in IDLE)
- st_addr  in  ADDR_W  byte address of the store
- st_data  in  32  register data; only the low 8/16/32 bits are stored
- st_size  in  2  store size: 00 byte, 01 halfword, 10 word, 11 illegal
- st_done  out  1  one-cycle pulse: store committed to memory
- st_err  out  1  one-cycle pulse: misaligned or illegal request, nothing written
- mem_addr  out  ADDR_W  word address, {addr[ADDR_W-1:2],2'b00}
- mem_rd_req  out  1  read request, held until mem_rd_ack
- mem_rd_ack  in  1  read complete; mem_rdata valid this cycle
- mem_rdata  in  32  read data
- mem_wr_req  out  1  write request, held until mem_wr_ack
- mem_wr_ack  in  1  write complete
- mem_wdata  out  32  write data

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low; asserting it forces IDLE immediately.
- Reset values: st_ready=1. st_done, st_err, mem_rd_req and mem_wr_req are 0. mem_addr, mem_wdata and the captured request registers are 0.
- Accept: a transfer happens when st_valid && st_ready on a rising edge. addr, data and size are captured in that cycle; the inputs are don't-care afterwards.
- Memory outputs: all mem_* outputs are registered or decoded from state, with no combinational path from st_* inputs.
- Handshake hold: a request stays asserted until its ack. An ack in the first cycle of the request counts. An ack seen while the matching request is low is ignored.
- Byte order is big-endian. Byte lane k=addr[1:0] maps to word bits [31-8k : 24-8k]. Halfword with addr[1]=0 maps to [31:16]; with addr[1]=1 it maps to [15:0].
- Alignment: halfword requires addr[0]=0. Word requires addr[1:0]=00. size=11 is always an error.
- FSM states: IDLE, READ, MERGE, WRITE, DONE, ERR.
  - IDLE: st_ready=1. On accept:
    - misaligned or illegal goes to ERR;
    - word goes to WRITE with mem_wdata=st_data;
    - byte or halfword goes to READ.
  - READ: mem_rd_req=1. On mem_rd_ack, capture mem_rdata and go to MERGE.
  - MERGE: replace the selected lane(s) of the captured word with st_data[7:0] or [15:0]. All other bits stay unchanged. Go to WRITE.
  - WRITE: mem_wr_req=1 and mem_wdata stable. On mem_wr_ack go to DONE.
  - DONE: st_done=1 for exactly one cycle, then IDLE.
  - ERR: st_err=1 for exactly one cycle, no memory request is issued, then IDLE.
- Latency with zero-wait memory (accept at cycle T):
  - word: WRITE at T+1, st_done at T+2, st_ready at T+3;
  - byte/half: READ T+1, MERGE T+2, WRITE T+3, st_done T+4;
  - error: st_err at T+1, ready at T+2.
- Each added memory wait cycle adds exactly one cycle.
- mem_addr is stable from the first READ/WRITE cycle through the last ack cycle.
- Reset mid-operation: the transaction is abandoned, no st_done is issued and the request drops at once. The memory tolerates a withdrawn request.
- Back-to-back: there is no overlap. A new request is accepted no earlier than the cycle after DONE or ERR.
- st_done and st_err are never high in the same cycle.

Decomposition:
- Package mem_store_pkg contains:
  - size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - state enum/encoding;
  - function is_misaligned(size, addr[1:0]).
- Combinational sub-module store_merge(old_word, data, size, lane) -> new_word holds the lane-insert logic and is unit-testable alone.

Test Plan:
- sw, addr 0x100, data 0xDEADBEEF, zero-wait memory -> no mem_rd_req; mem_wr_req at T+1 with mem_wdata=0xDEADBEEF, mem_addr=0x100; st_done at T+2.
- sb, addr 0x102, data 0x000000AB, memory holds 0x11223344 -> read of 0x100, write 0x1122AB44, st_done at T+4.
- sh, addr 0x106, data 0xFFFFCAFE, old 0x11223344 -> write 0x1122CAFE to 0x104; repeat with addr 0x104 -> 0xCAFE3344.
- sh at 0x101, sw at 0x102, size=11 at 0x100 -> st_err pulse at T+1, no mem request, st_ready back at T+2.
- sb with 3-cycle rd_ack and 2-cycle wr_ack delays -> requests held stable, mem_addr constant, st_done exactly 5 cycles later than the zero-wait case.
- rst_n low during WRITE -> outputs go to reset values asynchronously, no st_done; after release a sw completes normally.
